// File: rtl/addsub_pkg.sv
// Shared helpers for the pipelined add/subtract unit: mode encoding, slice width, parameter legality.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One CHUNK-bit carry-chain segment; registers sum slice, carry and valid (1 cycle).
// Holds all state while en_i is low; only the last segment produces signed overflow.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int CHUNK = 4,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic             vld_o,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o,
  output logic             ovf_o
);

  logic [CHUNK:0]   sum_d;
  logic [CHUNK-1:0] sum_q;
  logic             vld_q;
  logic             c_q;

  assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      sum_q <= '0;
      c_q   <= 1'b0;
    end else if (en_i) begin
      vld_q <= vld_i;
      sum_q <= sum_d[CHUNK-1:0];
      c_q   <= sum_d[CHUNK];
    end
  end

  assign vld_o = vld_q;
  assign sum_o = sum_q;
  assign c_o   = c_q;

  if (LAST) begin : g_ovf
    logic ovf_d;
    logic ovf_q;
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign ovf_d = (sum_d[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1]) ^ sum_d[CHUNK];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_q <= 1'b0;
      end else if (en_i) begin
        ovf_q <= ovf_d;
      end
    end
    assign ovf_o = ovf_q;
  end else begin : g_no_ovf
    assign ovf_o = 1'b0;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract split into STAGES registered carry segments; latency STAGES, 1 op/cycle.
// Single global enable: when the output is held (out_valid && !out_ready) everything freezes and in_ready drops.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [CHUNK-1:0] stg_a   [STAGES];
  logic [CHUNK-1:0] stg_b   [STAGES];
  logic [CHUNK-1:0] stg_sum [STAGES];
  logic [STAGES-1:0] stg_cin;
  logic [STAGES-1:0] stg_vin;
  logic [STAGES-1:0] stg_c;
  logic [STAGES-1:0] stg_vld;
  logic [STAGES-1:0] stg_ovf;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = (sub == MODE_SUB) ? ~b : b;
  assign c0       = (sub == MODE_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    localparam int DLY = STAGES - 1 - k;

    if (k == 0) begin : g_head
      assign stg_a[k]   = a[k*CHUNK +: CHUNK];
      assign stg_b[k]   = b_eff[k*CHUNK +: CHUNK];
      assign stg_cin[k] = c0;
      assign stg_vin[k] = in_valid;
    end else begin : g_skew
      logic [CHUNK-1:0] a_q [k];
      logic [CHUNK-1:0] b_q [k];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else if (advance) begin
          a_q[0] <= a[k*CHUNK +: CHUNK];
          b_q[0] <= b_eff[k*CHUNK +: CHUNK];
          for (int i = 1; i < k; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
        end
      end
      assign stg_a[k]   = a_q[k-1];
      assign stg_b[k]   = b_q[k-1];
      assign stg_cin[k] = stg_c[k-1];
      assign stg_vin[k] = stg_vld[k-1];
    end

    addsub_stage #(
      .CHUNK (CHUNK),
      .LAST  ((k == STAGES - 1) ? 1'b1 : 1'b0)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (advance),
      .vld_i (stg_vin[k]),
      .a_i   (stg_a[k]),
      .b_i   (stg_b[k]),
      .c_i   (stg_cin[k]),
      .vld_o (stg_vld[k]),
      .sum_o (stg_sum[k]),
      .c_o   (stg_c[k]),
      .ovf_o (stg_ovf[k])
    );

    if (DLY == 0) begin : g_no_deskew
      assign sum[k*CHUNK +: CHUNK] = stg_sum[k];
    end else begin : g_deskew
      logic [CHUNK-1:0] dly_q [DLY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DLY; i++) begin
            dly_q[i] <= '0;
          end
        end else if (advance) begin
          dly_q[0] <= stg_sum[k];
          for (int i = 1; i < DLY; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end
      assign sum[k*CHUNK +: CHUNK] = dly_q[DLY-1];
    end
  end

  assign out_valid = stg_vld[STAGES-1];
  assign cout      = stg_c[STAGES-1];
  // Only the last segment drives a nonzero overflow flag.
  assign ovf       = |stg_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=16, STAGES=4) with an arithmetic reference queue.
module tb_pipelined_addsub;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation as a whole.
  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv);
    res_t r;
    int   ua, ub, sa, sb, us, ss;
    ua = int'({16'b0, av});
    ub = int'({16'b0, bv});
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      us     = ua - ub;
      ss     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      us     = ua + ub + int'(cv);
      ss     = sa + sb + int'(cv);
      r.cout = (us > 65535);
    end
    r.sum = 16'(us);
    r.ovf = (ss > 32767) || (ss < -32768);
    return r;
  endfunction

  // Compare process: scoreboard, hold rule and ready rule on every cycle.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout, prev_ovf;
  initial begin
    res_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_sum", 32'(sum), 32'(prev_sum));
          chk("hold_cout", 32'(cout), 32'(prev_cout));
          chk("hold_ovf", 32'(ovf), 32'(prev_ovf));
        end
        chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result_valid", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("model_sum", 32'(sum), 32'(e.sum));
            chk("model_cout", 32'(cout), 32'(e.cout));
            chk("model_ovf", 32'(ovf), 32'(e.ovf));
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
        prev_cout  = cout;
        prev_ovf   = ovf;
      end
    end
  end

  task automatic run_single(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic sv,
                            input logic [W-1:0] es, input logic ec, input logic eo);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < S - 1; i++) begin
      chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int  idx;
    logic acc;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    run_single("add",      16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    run_single("ripple",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_single("sub_brw",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_single("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back: 8 ops, results must occupy edges S..S+7 exactly.
    for (int c = 0; c < 13; c++) begin
      a = 16'(c * 4099 + 7);
      b = 16'(c * 12345 + 3);
      sub = c[0];
      cin = c[1];
      in_valid = (c < 8);
      @(posedge clk); #1;
      chk("b2b_out_valid", 32'(out_valid), 32'((c + 1 >= S) && (c + 1 < S + 8)));
    end
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: out_ready low for three cycles in the middle of a 10-op stream.
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 6 && c < 9);
      a = 16'(idx * 7919 + 16'h8000);
      b = 16'(idx * 31337);
      sub = idx[1];
      cin = idx[0];
      in_valid = (idx < 10);
      @(negedge clk);
      if (c >= 6 && c < 9) begin
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_issued", 32'(idx), 32'd10);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-flight: a result on the outputs and three more in the pipe.
    for (int c = 0; c < 5; c++) begin
      a = 16'(16'h0101 * (c + 1));
      b = 16'h0011;
      sub = 1'b0;
      cin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("prerst_valid", 32'(out_valid), 32'd1);
    chk("prerst_sum", 32'(sum), 32'h0213);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_sum", 32'(sum), 32'd0);
    chk("rst_async_cout", 32'(cout), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      chk("postrst_no_stale", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_single("postrst", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
